// File: rtl/dmem_access_ctrl_d0.sv
// dmem_access_ctrl_d0
//
// Request/response front end for the synchronous-read data RAM
// ram_sync_read_d0. It turns a valid/ready stream of reads and
// byte-strobed writes into the RAM's addr/din/we controls. It captures the
// RAM's dout one cycle after the address is presented, and does
// read-modify-write for partial-strobe writes. Responses come back in
// order through a 4-entry FIFO.
//
// Ports
//   clock, reset_n           : clock, asynchronous active-low reset
//   req_valid / req_ready    : request handshake
//   req_we, req_addr,
//   req_wdata, req_be        : request payload (req_be ignored on reads)
//   rsp_valid / rsp_ready    : response handshake (head of the FIFO)
//   rsp_write, rsp_rdata     : 1 = write ack (rdata 0), 0 = read data
//   mem_addr, mem_din,
//   mem_we                   : RAM controls (combinational)
//   mem_dout                 : RAM read data, one cycle after mem_addr

module dmem_access_ctrl_d0 #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [AWIDTH-1:0]     req_addr,
    input  logic [DWIDTH-1:0]     req_wdata,
    input  logic [DWIDTH/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DWIDTH-1:0]     rsp_rdata,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH-1:0]     mem_din,
    output logic                  mem_we,
    input  logic [DWIDTH-1:0]     mem_dout
);

    localparam int BWIDTH = DWIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t              state_q;

    // Pending stage: one response owed for a request accepted last cycle
    logic                pend_valid_q;
    logic                pend_write_q;

    // Partial write held across the MERGE cycle
    logic [AWIDTH-1:0]   maddr_q;
    logic [DWIDTH-1:0]   mwdata_q;
    logic [BWIDTH-1:0]   mbe_q;

    // Response FIFO: {write flag, data} per entry
    logic [DWIDTH:0]     fifo_q [4];
    logic [1:0]          wptr_q;
    logic [1:0]          rptr_q;
    logic [2:0]          count_q;

    logic                accept;
    logic                be_full;
    logic                be_none;
    logic                is_partial;
    logic [3:0]          occupancy;
    logic [DWIDTH-1:0]   merge_data;
    logic                push;
    logic                push_write;
    logic [DWIDTH-1:0]   push_data;
    logic                pop;
    logic [DWIDTH:0]     head;

    assign be_full    = &req_be;
    assign be_none    = (req_be == '0);
    assign is_partial = req_we && !be_full && !be_none;

    // Slots already promised (queued plus the one in the pending stage) must
    // leave room for the new request. A pop in this cycle is deliberately not
    // credited, which keeps this path short.
    assign occupancy = {1'b0, count_q} + {3'b000, pend_valid_q};
    assign req_ready = reset_n && (state_q == IDLE) && (occupancy < 4'd4);
    assign accept    = req_valid && req_ready;

    // Old word from the RAM overlaid with the strobed bytes of the new data
    always_comb begin
        merge_data = mem_dout;
        for (int i = 0; i < BWIDTH; i++) begin
            if (mbe_q[i]) begin
                merge_data[8*i +: 8] = mwdata_q[8*i +: 8];
            end
        end
    end

    // RAM controls have to be combinational: the address of an accepted
    // request reaches the RAM in the same cycle so that read data returns
    // at T+1. mem_we is gated by reset so that a reset that lands in MERGE
    // cancels the merge write.
    always_comb begin
        mem_addr = req_addr;
        mem_din  = req_wdata;
        mem_we   = 1'b0;
        if (state_q == MERGE) begin
            mem_addr = maddr_q;
            mem_din  = merge_data;
            mem_we   = 1'b1;
        end else if (accept && req_we && be_full) begin
            mem_we = 1'b1;
        end
        if (!reset_n) begin
            mem_we = 1'b0;
        end
    end

    // Control FSM. A partial write reads the old word in the accept cycle
    // and writes the merged word in MERGE. Every other request goes through
    // the pending stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_write_q <= 1'b0;
            maddr_q      <= '0;
            mwdata_q     <= '0;
            mbe_q        <= '0;
        end else begin
            pend_valid_q <= 1'b0;
            pend_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_partial) begin
                            state_q  <= MERGE;
                            maddr_q  <= req_addr;
                            mwdata_q <= req_wdata;
                            mbe_q    <= req_be;
                        end else begin
                            pend_valid_q <= 1'b1;
                            pend_write_q <= req_we;
                        end
                    end
                end
                MERGE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // MERGE and the pending stage never push in the same cycle, because
    // a partial write does not load the pending stage.
    assign push       = pend_valid_q || (state_q == MERGE);
    assign push_write = pend_write_q || (state_q == MERGE);
    assign push_data  = push_write ? '0 : mem_dout;
    assign pop        = rsp_valid && rsp_ready;

    // Response FIFO with wrap-around pointers. req_ready guarantees that
    // a push never reaches a full FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= {push_write, push_data};
                wptr_q         <= wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            if (push && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 3'd1;
            end
        end
    end

    // Outputs come straight from FIFO registers. They are zeroed when the
    // FIFO is empty, so stale entries are never visible.
    assign head      = fifo_q[rptr_q];
    assign rsp_valid = (count_q != 3'd0);
    assign rsp_write = rsp_valid && head[DWIDTH];
    assign rsp_rdata = rsp_valid ? head[DWIDTH-1:0] : '0;

endmodule

// File: tb/tb_dmem_access_ctrl_d0.sv
// Testbench for dmem_access_ctrl_d0 with a behavioural synchronous-read RAM.
// A shadow memory predicts each response when the request is accepted. The
// prediction goes into a queue and is checked when the response handshakes.

module tb_dmem_access_ctrl_d0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [2:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;

    logic [31:0] ram [8];
    logic [31:0] shadow [8];

    typedef struct {
        logic        w;
        logic [31:0] d;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acceptCnt = 0;
    int rspCnt = 0;
    int dropped = 0;
    bit latOn = 1'b1;

    dmem_access_ctrl_d0 #(.AWIDTH(3), .DWIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural ram_sync_read_d0: write on we, registered read of old data
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Accept monitor: predicts the response and updates the shadow memory
    always @(negedge clock) begin
        if (reset_n && req_valid && req_ready) begin
            exp_t e;
            e.cyc = cyc;
            e.lat = latOn;
            if (req_we) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[b]) shadow[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                e.w = 1'b1;
                e.d = 32'h0;
            end else begin
                e.w = 1'b0;
                e.d = shadow[req_addr];
            end
            sb.push_back(e);
            acceptCnt++;
        end
    end

    // Response monitor
    always @(negedge clock) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            rspCnt++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_write", rsp_write, e.w);
                checkOutput("rsp_rdata", rsp_rdata, e.d);
                if (e.lat) checkOutput("latency", cyc - e.cyc, 2);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [2:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        forever begin
            @(negedge clock);
            if (req_ready) break;
            n++;
            if (n >= 50) begin
                checkOutput("accept_timeout", 0, 1);
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idleReq();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("drain", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] save3;
        int acc;

        for (int i = 0; i < 8; i++) begin
            ram[i] = 32'h0;
            shadow[i] = 32'h0;
        end

        // Reset values
        #12;
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_rsp_write", rsp_write, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("post_rst_req_ready", req_ready, 1);
        @(posedge clock);
        #1;

        // Full write then back-to-back read
        applyStimulus(1, 3'd5, 32'hDEADBEEF, 4'hF);
        applyStimulus(0, 3'd5, 32'h0, 4'h0);
        idleReq();
        waitDrain();

        // Partial write: one stall cycle, then read the merged word
        applyStimulus(1, 3'd5, 32'h0000AA00, 4'b0010);
        idleReq();
        @(negedge clock);
        checkOutput("merge_ready_low", req_ready, 0);
        @(negedge clock);
        checkOutput("merge_ready_back", req_ready, 1);
        @(posedge clock);
        #1;
        applyStimulus(0, 3'd5, 32'h0, 4'h0);
        idleReq();
        waitDrain();
        checkOutput("merge_word", shadow[5], 32'hDEADAAEF);

        // Fill memory, then stream eight reads
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 3'(i), 32'h11111111 * i, 4'hF);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 3'(i), 32'h0, 4'h0);
        idleReq();
        waitDrain();

        // Backpressure: only four reads fit while responses are held
        latOn = 1'b0;
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 3'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (req_ready) begin
                @(posedge clock);
                #1;
                acc++;
                req_addr = 3'(acc);
            end else begin
                @(posedge clock);
                #1;
            end
        end
        idleReq();
        checkOutput("bp_accepts", acc, 4);
        @(negedge clock);
        checkOutput("bp_ready_low", req_ready, 0);
        held = rsp_rdata;
        checkOutput("bp_head", held, 32'h00000000);
        repeat (3) @(negedge clock);
        checkOutput("bp_stable_valid", rsp_valid, 1);
        checkOutput("bp_stable_data", rsp_rdata, held);
        rsp_ready = 1'b1;
        applyStimulus(0, 3'd4, 32'h0, 4'h0);
        applyStimulus(0, 3'd5, 32'h0, 4'h0);
        idleReq();
        waitDrain();
        latOn = 1'b1;

        // Reset during MERGE of a partial write to addr 3
        save3 = shadow[3];
        applyStimulus(1, 3'd3, 32'h000000FF, 4'b0001);
        idleReq();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mrst_rsp_valid", rsp_valid, 0);
        checkOutput("mrst_mem_we", mem_we, 0);
        dropped = dropped + sb.size();
        sb.delete();
        shadow[3] = save3;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("mrst_req_ready", req_ready, 1);
        checkOutput("mrst_ram3", ram[3], 32'h33333333);
        @(posedge clock);
        #1;
        applyStimulus(0, 3'd3, 32'h0, 4'h0);
        idleReq();
        waitDrain();

        // Empty strobe write leaves memory alone
        applyStimulus(1, 3'd2, 32'hFFFFFFFF, 4'h0);
        applyStimulus(0, 3'd2, 32'h0, 4'h0);
        idleReq();
        waitDrain();
        checkOutput("empty_be_ram2", ram[2], 32'h22222222);

        checkOutput("rsp_count", rspCnt, acceptCnt - dropped);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_access_ctrl_d0.md
# dmem_access_ctrl_d0

Request/response front end that sits directly upstream of the synchronous-read data RAM `ram_sync_read_d0`. It turns a valid/ready request stream of reads and byte-strobed writes into the RAM's `addr`/`din`/`we` controls. It captures `dout` at the one correct cycle of the RAM's read latency, performs read-modify-write for partial writes, and returns one in-order response per request through a 4-entry response FIFO with backpressure.

## Interface
- `AWIDTH`, default 3, address width; must match the RAM.
- `DWIDTH`, default 32, data width; must be a multiple of 8. `BWIDTH = DWIDTH/8` is the derived strobe width.
- `clock`, in, 1, single clock for the block and the RAM.
- `reset_n`, in, 1, asynchronous, active-low reset.
- `req_valid`, in, 1, request present.
- `req_ready`, out, 1, request accepted when `req_valid & req_ready` at a rising edge.
- `req_we`, in, 1, 1 = write, 0 = read.
- `req_addr`, in, AWIDTH, word address.
- `req_wdata`, in, DWIDTH, write data.
- `req_be`, in, BWIDTH, byte enables; `req_be[i]` covers bits `[8i+7:8i]`. Ignored on reads.
- `rsp_valid`, out, 1, response present (head of the FIFO).
- `rsp_ready`, in, 1, response consumed when `rsp_valid & rsp_ready`.
- `rsp_write`, out, 1, 1 = write acknowledge, 0 = read data.
- `rsp_rdata`, out, DWIDTH, read data; 0 for write acknowledges.
- `mem_addr`, out, AWIDTH, to RAM `addr`.
- `mem_din`, out, DWIDTH, to RAM `din`.
- `mem_we`, out, 1, to RAM `we`.
- `mem_dout`, in, DWIDTH, from RAM `dout`; valid one cycle after the address is presented.

## Operation
- FSM states are IDLE and MERGE. Reset enters IDLE.
- `req_ready = (state==IDLE) && (fifo_count + pend_valid < 4)`. A pop in the same cycle is not credited; this is conservative by design.
- **IDLE, request accepted (cycle T):**
  - `mem_addr = req_addr`.
  - **Read:** `mem_we=0`. The pending stage loads `{valid, read}`.
  - **Full write (`req_be` all ones):** `mem_we=1`, `mem_din=req_wdata`. The pending stage loads `{valid, write}`.
  - **Write with `req_be==0`:** `mem_we=0`; memory is unchanged. The pending stage loads `{valid, write}`.
  - **Partial write:** `mem_we=0`, which reads the old word. The block latches addr, wdata and be, then goes to MERGE.
- **MERGE (cycle T+1):**
  - `mem_addr` = latched addr, `mem_we=1`.
  - `mem_din` = per byte, latched wdata where be=1, otherwise `mem_dout`.
  - `req_ready=0`. A write ack is pushed at the end of this cycle, then the FSM returns to IDLE.
- **Pending stage (cycle T+1):** pushes `{rsp_write, rsp_rdata}` into the FIFO. The data is `mem_dout` for a read and 0 for a write.
- **IDLE with no accept:** `mem_we=0`, `mem_addr=req_addr`, `mem_din=req_wdata`. These are don't-care for the RAM.
- Responses leave in strict acceptance order; exactly one response per accepted request.
- **Hazards:**
  - A read accepted after a write to the same address sees the new data. A full write commits at the edge ending T. MERGE blocks acceptance until its write commits.
- FIFO: 4 entries, binary wrap-around pointers, 3-bit count. A push and a pop in the same cycle keep the count unchanged. A push is never presented to a full FIFO; this is guaranteed by the `req_ready` rule.

## Timing
- **Reset (async assert, applied immediately):**
  - state=IDLE, pending cleared, FIFO emptied.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_write=0`, `mem_we=0`.
  - `req_ready=1` once `reset_n` is high; during reset it is forced to 0.
- `mem_we` is forced to 0 while `reset_n=0`. A reset in MERGE aborts the merge write and leaves memory unchanged.
- In-flight requests and queued responses are dropped on reset; RAM contents are retained.
- **Latency:** accept at edge ending cycle T, `rsp_valid` in cycle T+2, for all request types.
- **Throughput:** one request per cycle for reads, full writes and `be==0` writes, when `rsp_ready=1`. A partial write occupies 2 cycles.
- `rsp_*` are registered FIFO-head outputs. While `rsp_valid=1 & rsp_ready=0` they hold stable.

## Test plan
- **Full write then read:** reset; write addr 5 with 0xDEADBEEF and be=4'hF, then read addr 5 back-to-back. Required: ack (`rsp_write=1`, `rsp_rdata=0`) 2 cycles after the write accept, then read data 0xDEADBEEF on the next cycle.
- **Partial write:** write addr 5 with data 0x0000AA00 and be=4'b0010, then read addr 5. Required: `req_ready=0` for exactly 1 cycle, ack returned, read returns 0xDEADAAEF.
- **Streaming reads:** after writing `mem[i]=i*0x11111111`, read addrs 0..7 with `rsp_ready=1`. Required: 8 in-order responses on 8 consecutive cycles, first at T+2.
- **Backpressure:** hold `rsp_ready=0` and issue 6 reads. Required: exactly 4 accepted, then `req_ready=0`; FIFO outputs stay stable. Raise `rsp_ready`: all 6 responses arrive in order with no loss or duplication.
- **Reset during MERGE:** assert `reset_n=0` during the MERGE cycle of a partial write to addr 3. Required: `mem[3]` unchanged, `rsp_valid=0` immediately, `req_ready=1` in the first cycle after release.
- **Empty strobe:** write addr 2 with be=4'h0. Required: memory unchanged, ack returned at T+2.
